// File: rtl/tile_config_pkg.sv
// Shared types and helpers for the tile configuration loader.
package tile_config_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        SHIFT  = 3'd2,
        COMMIT = 3'd3,
        RUN    = 3'd4,
        ERROR  = 3'd5
    } state_t;

    localparam logic [7:0] CRC8_POLY             = 8'h07;
    localparam int         TILE_CONFIG_W_DEFAULT = 146;

    // One serial step of CRC-8, MSB-first feedback.
    function automatic logic [7:0] crc8_bit(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/word_serializer.sv
// Word buffer and bit counters driving the serial config chain LSB-first.
module word_serializer #(
    parameter int WORD_W     = 8,
    parameter int TOTAL_BITS = 146
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_word,
    input  logic              i_shift,
    output logic              o_cfg_data,
    output logic              o_cfg_shift,
    output logic              o_word_last,
    output logic              o_chain_last
);

    localparam int CNT_W  = $clog2(TOTAL_BITS + 1);
    localparam int WCNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TOTAL_BITS - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(TOTAL_BITS);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WORD_W - 1);

    logic [WORD_W-1:0] r_buf;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [WCNT_W-1:0] r_word_cnt;

    // Buffer load/shift and saturating chain bit counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_buf      <= '0;
            r_bit_cnt  <= '0;
            r_word_cnt <= '0;
        end else if (i_clear) begin
            r_buf      <= '0;
            r_bit_cnt  <= '0;
            r_word_cnt <= '0;
        end else if (i_load) begin
            r_buf      <= i_word;
            r_word_cnt <= '0;
        end else if (i_shift) begin
            r_buf      <= {1'b0, r_buf[WORD_W-1:1]};
            r_word_cnt <= r_word_cnt + WCNT_W'(1);
            if (r_bit_cnt != CNT_FULL) begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
        end
    end

    // The final partial word ends early at the chain length, dropping its upper bits.
    assign o_chain_last = (r_bit_cnt == CNT_LAST);
    assign o_word_last  = (r_word_cnt == WCNT_LAST) || o_chain_last;
    assign o_cfg_shift  = i_shift;
    assign o_cfg_data   = i_shift & r_buf[0];

endmodule

// File: rtl/tile_config_loader.sv
// Streams the config bitstream into the tile chain, commits it, releases fabric reset.
// Optional trailer CRC check enabled by TILE_CONFIG_LOADER_CRC_EN.
module tile_config_loader
    import tile_config_pkg::*;
#(
    parameter int TILE_CONFIG_W = TILE_CONFIG_W_DEFAULT,
    parameter int NUM_TILES     = 4,
    parameter int WORD_W        = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              cfg_data,
    output logic              cfg_shift,
    output logic              cfg_commit,
    output logic              fabric_nreset,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int TOTAL_BITS = TILE_CONFIG_W * NUM_TILES;

    state_t r_state;
    state_t w_next_state;
    logic   w_clear;
    logic   w_load;
    logic   w_shift;
    logic   w_word_last;
    logic   w_chain_last;
    logic   w_cfg_data;
    logic   r_in_ready;
    logic   r_busy;
    logic   r_commit;
    logic   r_done;
    logic   r_nreset;

    assign w_shift = (r_state == SHIFT);

    word_serializer #(
        .WORD_W     (WORD_W),
        .TOTAL_BITS (TOTAL_BITS)
    ) u_serializer (
        .clock        (clock),
        .reset        (reset),
        .i_clear      (w_clear),
        .i_load       (w_load),
        .i_word       (in_data),
        .i_shift      (w_shift),
        .o_cfg_data   (w_cfg_data),
        .o_cfg_shift  (cfg_shift),
        .o_word_last  (w_word_last),
        .o_chain_last (w_chain_last)
    );

`ifdef TILE_CONFIG_LOADER_CRC_EN
    logic [7:0] r_crc;
    logic       r_trailer;
    logic       r_error;

    // Running CRC over shifted bits; trailer flag marks the extra FETCH.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_crc     <= 8'h00;
            r_trailer <= 1'b0;
        end else if (w_clear) begin
            r_crc     <= 8'h00;
            r_trailer <= 1'b0;
        end else if (w_shift) begin
            r_crc <= crc8_bit(r_crc, w_cfg_data);
            if (w_word_last && w_chain_last) begin
                r_trailer <= 1'b1;
            end
        end
    end
`endif

    // Next-state and serializer control.
    always_comb begin
        w_next_state = r_state;
        w_clear      = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            IDLE, RUN: begin
                if (start) begin
                    w_next_state = FETCH;
                    w_clear      = 1'b1;
                end else begin
                    w_next_state = r_state;
                end
            end
`ifdef TILE_CONFIG_LOADER_CRC_EN
            ERROR: begin
                if (start) begin
                    w_next_state = FETCH;
                    w_clear      = 1'b1;
                end else begin
                    w_next_state = r_state;
                end
            end
`endif
            FETCH: begin
                if (in_valid && r_in_ready) begin
`ifdef TILE_CONFIG_LOADER_CRC_EN
                    if (!r_trailer) begin
                        w_next_state = SHIFT;
                        w_load       = 1'b1;
                    end else if (in_data[7:0] == r_crc) begin
                        w_next_state = COMMIT;
                    end else begin
                        w_next_state = ERROR;
                    end
`else
                    w_next_state = SHIFT;
                    w_load       = 1'b1;
`endif
                end else begin
                    w_next_state = r_state;
                end
            end
            SHIFT: begin
                if (w_word_last) begin
`ifdef TILE_CONFIG_LOADER_CRC_EN
                    w_next_state = FETCH;
`else
                    if (w_chain_last) begin
                        w_next_state = COMMIT;
                    end else begin
                        w_next_state = FETCH;
                    end
`endif
                end else begin
                    w_next_state = r_state;
                end
            end
            COMMIT:  w_next_state = RUN;
            default: w_next_state = IDLE;
        endcase
    end

    // State register; status outputs are registered decodes of the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_commit   <= 1'b0;
            r_done     <= 1'b0;
            r_nreset   <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state == FETCH);
            r_busy     <= (w_next_state == FETCH) || (w_next_state == SHIFT) ||
                          (w_next_state == COMMIT);
            r_commit   <= (w_next_state == COMMIT);
            r_done     <= (w_next_state == RUN);
            r_nreset   <= (w_next_state == RUN);
        end
    end

`ifdef TILE_CONFIG_LOADER_CRC_EN
    // Error flag follows the ERROR state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_error <= 1'b0;
        end else begin
            r_error <= (w_next_state == ERROR);
        end
    end
    assign error = r_error;
`else
    assign error = 1'b0;
`endif

    assign in_ready      = r_in_ready;
    assign cfg_data      = w_cfg_data;
    assign cfg_commit    = r_commit;
    assign fabric_nreset = r_nreset;
    assign busy          = r_busy;
    assign done          = r_done;

endmodule

// File: tb/tb_tile_config_loader.sv
// Directed self-checking bench for tile_config_loader (1 tile x 146 bits, 8-bit words).
module tb_tile_config_loader;

    localparam int TOTAL  = 146;
    localparam int NWORDS = 19;
`ifdef TILE_CONFIG_LOADER_CRC_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int NSEND    = NWORDS + EXTRA;
    localparam int LOAD_CYC = 165 + EXTRA;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready, cfg_data, cfg_shift, cfg_commit;
    logic       fabric_nreset, busy, done, error;

    int checks   = 0;
    int failures = 0;

    int   mon_shifts  = 0;
    int   mon_commits = 0;
    logic cap [0:4095];

    always #5 clock = ~clock;

    tile_config_loader #(
        .TILE_CONFIG_W (146),
        .NUM_TILES     (1),
        .WORD_W        (8)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .cfg_data      (cfg_data),
        .cfg_shift     (cfg_shift),
        .cfg_commit    (cfg_commit),
        .fabric_nreset (fabric_nreset),
        .busy          (busy),
        .done          (done),
        .error         (error)
    );

    // Capture the serial chain and count commit strobes mid-cycle.
    always @(negedge clock) begin
        if (cfg_shift === 1'b1) begin
            cap[mon_shifts] <= cfg_data;
            mon_shifts      <= mon_shifts + 1;
        end
        if (cfg_commit === 1'b1) begin
            mon_commits <= mon_commits + 1;
        end
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    function automatic logic [7:0] word_val(input int idx, input logic [7:0] off);
        return 8'(idx) + off;
    endfunction

    function automatic logic exp_bit(input int j, input logic [7:0] off);
        logic [7:0] w;
        w = word_val(j / 8, off);
        return w[j % 8];
    endfunction

    function automatic logic [7:0] crc_model(input logic [7:0] off);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int j = 0; j < TOTAL; j++) begin
            fb = c[7] ^ exp_bit(j, off);
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
        end
        return c;
    endfunction

    function automatic logic [7:0] stream_word(input int idx, input logic [7:0] off,
                                               input logic [7:0] flip);
        if (idx < NWORDS) return word_val(idx, off);
        return crc_model(off) ^ flip;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Feeds a stream from FETCH; optional gap, stray start during SHIFT, or early abort.
    task automatic drive_load(input logic [7:0] off, input logic [7:0] flip,
                              input int gap_word, input int start_word, input int abort_idx,
                              output int cyc, output logic saw_commit, output logic saw_error);
        int   idx = 0;
        logic gap_done = 1'b0;
        logic start_done = 1'b0;
        logic acc;
        cyc = 0;
        saw_commit = 1'b0;
        saw_error = 1'b0;
        while (!saw_commit && !saw_error && cyc < 600 && idx != abort_idx) begin
            if (gap_word >= 0 && !gap_done && in_ready === 1'b1 && idx == gap_word) begin
                in_valid = 1'b0;
                repeat (5) begin
                    checks += 2;
                    if (in_ready !== 1'b1) begin
                        failures++;
                        $display("FAIL gap_ready: in_ready=%b required 1", in_ready);
                    end
                    if (cfg_shift !== 1'b0) begin
                        failures++;
                        $display("FAIL gap_shift: cfg_shift=%b required 0", cfg_shift);
                    end
                    step();
                    cyc++;
                end
                gap_done = 1'b1;
            end else begin
                start = (start_word >= 0 && !start_done && cfg_shift === 1'b1 && idx == start_word);
                if (start) start_done = 1'b1;
                in_valid = (idx < NSEND);
                in_data  = (idx < NSEND) ? stream_word(idx, off, flip) : 8'h00;
                acc = in_valid && (in_ready === 1'b1);
                step();
                cyc++;
                start = 1'b0;
                if (acc) idx++;
                if (cfg_commit === 1'b1) saw_commit = 1'b1;
                if (error === 1'b1) saw_error = 1'b1;
            end
        end
        in_valid = 1'b0;
        start    = 1'b0;
        checks++;
        if (cyc >= 600) begin
            failures++;
            $display("FAIL load_timeout: cycles=%0d required <600", cyc);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        checks += 8;
        if (in_ready !== 1'b0)      begin failures++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
        if (cfg_shift !== 1'b0)     begin failures++; $display("FAIL rst_cfg_shift: got %b required 0", cfg_shift); end
        if (cfg_data !== 1'b0)      begin failures++; $display("FAIL rst_cfg_data: got %b required 0", cfg_data); end
        if (cfg_commit !== 1'b0)    begin failures++; $display("FAIL rst_commit: got %b required 0", cfg_commit); end
        if (busy !== 1'b0)          begin failures++; $display("FAIL rst_busy: got %b required 0", busy); end
        if (done !== 1'b0)          begin failures++; $display("FAIL rst_done: got %b required 0", done); end
        if (error !== 1'b0)         begin failures++; $display("FAIL rst_error: got %b required 0", error); end
        if (fabric_nreset !== 1'b0) begin failures++; $display("FAIL rst_nreset: got %b required 0", fabric_nreset); end
        reset = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL idle_hold: busy=%b in_ready=%b required 0 0", busy, in_ready);
        end
    endtask

    task automatic test_full_load();
        int cyc, base, cbase, errs;
        logic sc, se;
        pulse_start();
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL start_fetch: busy=%b in_ready=%b required 1 1", busy, in_ready);
        end
        base = mon_shifts;
        cbase = mon_commits;
        drive_load(8'h00, 8'h00, -1, -1, -1, cyc, sc, se);
        checks += 2;
        if (cyc !== LOAD_CYC) begin failures++; $display("FAIL full_cycles: got %0d required %0d", cyc, LOAD_CYC); end
        if (done !== 1'b0 || fabric_nreset !== 1'b0) begin
            failures++;
            $display("FAIL commit_cycle: done=%b nreset=%b required 0 0", done, fabric_nreset);
        end
        step();
        checks += 3;
        if (done !== 1'b1 || fabric_nreset !== 1'b1) begin
            failures++;
            $display("FAIL run_state: done=%b nreset=%b required 1 1", done, fabric_nreset);
        end
        if (busy !== 1'b0 || cfg_commit !== 1'b0) begin
            failures++;
            $display("FAIL run_idle: busy=%b commit=%b required 0 0", busy, cfg_commit);
        end
        if (mon_shifts - base !== TOTAL) begin
            failures++;
            $display("FAIL full_shifts: got %0d required %0d", mon_shifts - base, TOTAL);
        end
        errs = 0;
        for (int j = 0; j < TOTAL; j++) if (cap[base + j] !== exp_bit(j, 8'h00)) errs++;
        checks += 3;
        if (errs != 0) begin failures++; $display("FAIL full_bits: %0d bit errors required 0", errs); end
        if (cap[base + 144] !== 1'b0 || cap[base + 145] !== 1'b1) begin
            failures++;
            $display("FAIL last_word_bits: got %b%b required 10", cap[base + 145], cap[base + 144]);
        end
        step();
        if (mon_commits - cbase !== 1) begin
            failures++;
            $display("FAIL full_commits: got %0d required 1", mon_commits - cbase);
        end
    endtask

    task automatic test_restart();
        int cyc, base, cbase, errs;
        logic sc, se;
        pulse_start();
        checks++;
        if (done !== 1'b0 || fabric_nreset !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL restart: done=%b nreset=%b busy=%b required 0 0 1", done, fabric_nreset, busy);
        end
        base = mon_shifts;
        cbase = mon_commits;
        drive_load(8'h40, 8'h00, -1, -1, -1, cyc, sc, se);
        step();
        errs = 0;
        for (int j = 0; j < TOTAL; j++) if (cap[base + j] !== exp_bit(j, 8'h40)) errs++;
        checks += 3;
        if (errs != 0) begin failures++; $display("FAIL restart_bits: %0d bit errors required 0", errs); end
        if (mon_commits - cbase !== 1) begin failures++; $display("FAIL restart_commits: got %0d required 1", mon_commits - cbase); end
        if (done !== 1'b1) begin failures++; $display("FAIL restart_done: got %b required 1", done); end
    endtask

    task automatic test_gap();
        int cyc, base, cbase, errs;
        logic sc, se;
        pulse_start();
        base = mon_shifts;
        cbase = mon_commits;
        drive_load(8'h80, 8'h00, 5, -1, -1, cyc, sc, se);
        step();
        errs = 0;
        for (int j = 0; j < TOTAL; j++) if (cap[base + j] !== exp_bit(j, 8'h80)) errs++;
        checks += 4;
        if (cyc !== LOAD_CYC + 5) begin failures++; $display("FAIL gap_cycles: got %0d required %0d", cyc, LOAD_CYC + 5); end
        if (mon_shifts - base !== TOTAL) begin failures++; $display("FAIL gap_shifts: got %0d required %0d", mon_shifts - base, TOTAL); end
        if (errs != 0) begin failures++; $display("FAIL gap_bits: %0d bit errors required 0", errs); end
        if (mon_commits - cbase !== 1) begin failures++; $display("FAIL gap_commits: got %0d required 1", mon_commits - cbase); end
    endtask

    task automatic test_reset_midload();
        int cyc, base, cbase, errs;
        logic sc, se;
        pulse_start();
        cbase = mon_commits;
        drive_load(8'h00, 8'h00, -1, -1, 8, cyc, sc, se);
        reset = 1'b1;
        step();
        checks++;
        if ({in_ready, cfg_shift, cfg_data, cfg_commit, busy, done, error, fabric_nreset} !== 8'h00) begin
            failures++;
            $display("FAIL midload_reset: outputs=%b required 00000000",
                     {in_ready, cfg_shift, cfg_data, cfg_commit, busy, done, error, fabric_nreset});
        end
        step();
        reset = 1'b0;
        repeat (3) step();
        checks++;
        if (mon_commits - cbase !== 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midload_commit: commits=%0d busy=%b required 0 0", mon_commits - cbase, busy);
        end
        pulse_start();
        base = mon_shifts;
        cbase = mon_commits;
        drive_load(8'h11, 8'h00, -1, -1, -1, cyc, sc, se);
        step();
        errs = 0;
        for (int j = 0; j < TOTAL; j++) if (cap[base + j] !== exp_bit(j, 8'h11)) errs++;
        checks += 2;
        if (errs != 0) begin failures++; $display("FAIL reload_bits: %0d bit errors required 0", errs); end
        if (mon_commits - cbase !== 1 || done !== 1'b1) begin
            failures++;
            $display("FAIL reload_commit: commits=%0d done=%b required 1 1", mon_commits - cbase, done);
        end
    endtask

    task automatic test_ignored();
        int cyc, base, cbase, errs;
        logic sc, se;
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        base = mon_shifts;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        repeat (3) step();
        in_valid = 1'b0;
        checks++;
        if (mon_shifts - base !== 0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL idle_valid: shifts=%0d busy=%b in_ready=%b required 0 0 0",
                     mon_shifts - base, busy, in_ready);
        end
        pulse_start();
        base = mon_shifts;
        cbase = mon_commits;
        drive_load(8'h22, 8'h00, -1, 3, -1, cyc, sc, se);
        step();
        errs = 0;
        for (int j = 0; j < TOTAL; j++) if (cap[base + j] !== exp_bit(j, 8'h22)) errs++;
        checks += 4;
        if (cyc !== LOAD_CYC) begin failures++; $display("FAIL busy_start_cycles: got %0d required %0d", cyc, LOAD_CYC); end
        if (mon_shifts - base !== TOTAL) begin failures++; $display("FAIL busy_start_shifts: got %0d required %0d", mon_shifts - base, TOTAL); end
        if (errs != 0) begin failures++; $display("FAIL busy_start_bits: %0d bit errors required 0", errs); end
        if (mon_commits - cbase !== 1) begin failures++; $display("FAIL busy_start_commits: got %0d required 1", mon_commits - cbase); end
    endtask

`ifdef TILE_CONFIG_LOADER_CRC_EN
    task automatic test_crc();
        int cyc, cbase;
        logic sc, se;
        pulse_start();
        cbase = mon_commits;
        drive_load(8'h33, 8'h00, -1, -1, -1, cyc, sc, se);
        step();
        checks++;
        if (mon_commits - cbase !== 1 || error !== 1'b0 || done !== 1'b1) begin
            failures++;
            $display("FAIL crc_good: commits=%0d error=%b done=%b required 1 0 1", mon_commits - cbase, error, done);
        end
        pulse_start();
        cbase = mon_commits;
        drive_load(8'h33, 8'h01, -1, -1, -1, cyc, sc, se);
        step();
        checks += 2;
        if (error !== 1'b1 || busy !== 1'b0 || fabric_nreset !== 1'b0) begin
            failures++;
            $display("FAIL crc_bad: error=%b busy=%b nreset=%b required 1 0 0", error, busy, fabric_nreset);
        end
        if (mon_commits - cbase !== 0) begin failures++; $display("FAIL crc_bad_commit: got %0d required 0", mon_commits - cbase); end
        pulse_start();
        checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL crc_clear: error=%b busy=%b required 0 1", error, busy);
        end
        cbase = mon_commits;
        drive_load(8'h33, 8'h00, -1, -1, -1, cyc, sc, se);
        step();
        checks++;
        if (mon_commits - cbase !== 1 || done !== 1'b1 || error !== 1'b0) begin
            failures++;
            $display("FAIL crc_recover: commits=%0d done=%b error=%b required 1 1 0", mon_commits - cbase, done, error);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_load();
        test_restart();
        test_gap();
        test_reset_midload();
        test_ignored();
`ifdef TILE_CONFIG_LOADER_CRC_EN
        test_crc();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
